// File: rtl/rob_retire_unit.sv
// rob_retire_unit: re-order buffer sitting between dispatch/rename and the
// register file / data memory. Up to DISP_W entries are allocated per cycle in
// program order. NUM_CMP tagged completions are accepted per cycle. Up to RET_W
// completed entries retire per cycle, strictly in order, on registered outputs.
// Optional feature macro: ROB_FLUSH_EN adds flush_i, which invalidates every entry.
module rob_retire_unit #(
    parameter int DEPTH   = 16,
    parameter int DISP_W  = 2,
    parameter int NUM_CMP = 3,
    parameter int RET_W   = 2,
    parameter int PREG_W  = 6,
    parameter int DATA_W  = 32,
    parameter int PC_W    = 7,
    localparam int TAG_W  = $clog2(DEPTH)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
`ifdef ROB_FLUSH_EN
    input  logic                        flush_i,
`endif
    input  logic [DISP_W-1:0]           disp_valid_i,
    output logic                        disp_ready_o,
    input  logic [2*DISP_W-1:0]         disp_type_i,
    input  logic [PREG_W*DISP_W-1:0]    disp_pd_i,
    input  logic [PREG_W*DISP_W-1:0]    disp_old_pd_i,
    input  logic [PC_W*DISP_W-1:0]      disp_pc_i,
    output logic [TAG_W*DISP_W-1:0]     disp_tag_o,
    input  logic [NUM_CMP-1:0]          cmp_valid_i,
    input  logic [TAG_W*NUM_CMP-1:0]    cmp_tag_i,
    input  logic [DATA_W*NUM_CMP-1:0]   cmp_result_i,
    output logic [RET_W-1:0]            rt_valid_o,
    output logic [2*RET_W-1:0]          rt_type_o,
    output logic [PREG_W*RET_W-1:0]     rt_pd_o,
    output logic [PREG_W*RET_W-1:0]     rt_old_pd_o,
    output logic [DATA_W*RET_W-1:0]     rt_result_o,
    output logic [PC_W*RET_W-1:0]       rt_pc_o,
    output logic [TAG_W:0]              count_o,
    output logic                        empty_o,
    output logic                        full_o
);

    localparam int CNT_W = TAG_W + 1;

    // Ring pointers, occupancy and per-entry state
    logic [TAG_W-1:0]  r_head;
    logic [TAG_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  r_comp;
    logic [1:0]        r_type   [DEPTH];
    logic [PREG_W-1:0] r_pd     [DEPTH];
    logic [PREG_W-1:0] r_old_pd [DEPTH];
    logic [PC_W-1:0]   r_pc     [DEPTH];
    logic [DATA_W-1:0] r_result [DEPTH];

    // Registered retirement outputs
    logic [RET_W-1:0]        r_rt_valid;
    logic [2*RET_W-1:0]      r_rt_type;
    logic [PREG_W*RET_W-1:0] r_rt_pd;
    logic [PREG_W*RET_W-1:0] r_rt_old_pd;
    logic [DATA_W*RET_W-1:0] r_rt_result;
    logic [PC_W*RET_W-1:0]   r_rt_pc;

    logic [TAG_W-1:0] w_disp_idx [DISP_W];
    logic [TAG_W-1:0] w_ret_idx  [RET_W];
    logic [CNT_W-1:0] w_free;
    logic [CNT_W-1:0] w_disp_n;
    logic [CNT_W-1:0] w_disp_eff;
    logic [CNT_W-1:0] w_ret_n;
    logic [RET_W-1:0] w_ret_ok;
    logic             w_ready;
    logic             w_do_disp;
    logic             w_flush;

`ifdef ROB_FLUSH_EN
    assign w_flush = flush_i;
`else
    assign w_flush = 1'b0;
`endif

    // Free-space check, dispatch slot addresses and lane count, all from registered state
    always_comb begin
        w_free     = CNT_W'(DEPTH) - r_count;
        w_ready    = (w_free >= CNT_W'(DISP_W));
        w_do_disp  = w_ready && (|disp_valid_i);
        w_disp_n   = '0;
        disp_tag_o = '0;
        for (int i = 0; i < DISP_W; i++) begin
            w_disp_idx[i] = r_tail + TAG_W'(i);
            disp_tag_o[TAG_W*i +: TAG_W] = w_disp_idx[i];
            if (disp_valid_i[i]) begin
                w_disp_n = w_disp_n + CNT_W'(1);
            end else begin
                w_disp_n = w_disp_n;
            end
        end
        w_disp_eff = w_do_disp ? w_disp_n : '0;
    end

    // In-order retire scan: slot k retires only if every older slot also retires
    always_comb begin
        logic l_run;
        l_run    = 1'b1;
        w_ret_ok = '0;
        w_ret_n  = '0;
        for (int k = 0; k < RET_W; k++) begin
            w_ret_idx[k] = r_head + TAG_W'(k);
            if (l_run && r_valid[w_ret_idx[k]] && r_comp[w_ret_idx[k]]) begin
                w_ret_ok[k] = 1'b1;
                w_ret_n     = w_ret_n + CNT_W'(1);
            end else begin
                l_run = 1'b0;
            end
        end
    end

    // Pointers, occupancy and valid/comp bits; flush wins over all other updates
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
            r_comp  <= '0;
        end else if (w_flush) begin
            r_head  <= r_tail;
            r_count <= '0;
            r_valid <= '0;
            r_comp  <= '0;
        end else begin
            // ascending port order lets the highest port index win on a shared tag
            for (int p = 0; p < NUM_CMP; p++) begin
                if (cmp_valid_i[p] && r_valid[cmp_tag_i[TAG_W*p +: TAG_W]]) begin
                    r_comp[cmp_tag_i[TAG_W*p +: TAG_W]] <= 1'b1;
                end
            end
            for (int k = 0; k < RET_W; k++) begin
                if (w_ret_ok[k]) begin
                    r_valid[w_ret_idx[k]] <= 1'b0;
                    r_comp[w_ret_idx[k]]  <= 1'b0;
                end
            end
            // dispatch targets free slots, so it never collides with retire or completion
            if (w_do_disp) begin
                for (int i = 0; i < DISP_W; i++) begin
                    if (disp_valid_i[i]) begin
                        r_valid[w_disp_idx[i]] <= 1'b1;
                        r_comp[w_disp_idx[i]]  <= 1'b0;
                    end
                end
            end
            r_head  <= TAG_W'(CNT_W'(r_head) + w_ret_n);
            r_tail  <= TAG_W'(CNT_W'(r_tail) + w_disp_eff);
            r_count <= r_count + w_disp_eff - w_ret_n;
        end
    end

    // Entry payload: written at dispatch, result overwritten by completions
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int e = 0; e < DEPTH; e++) begin
                r_type[e]   <= 2'd0;
                r_pd[e]     <= '0;
                r_old_pd[e] <= '0;
                r_pc[e]     <= '0;
                r_result[e] <= '0;
            end
        end else if (!w_flush) begin
            for (int p = 0; p < NUM_CMP; p++) begin
                if (cmp_valid_i[p] && r_valid[cmp_tag_i[TAG_W*p +: TAG_W]]) begin
                    r_result[cmp_tag_i[TAG_W*p +: TAG_W]] <= cmp_result_i[DATA_W*p +: DATA_W];
                end
            end
            if (w_do_disp) begin
                for (int i = 0; i < DISP_W; i++) begin
                    if (disp_valid_i[i]) begin
                        // the reserved type code is stored as ALU
                        r_type[w_disp_idx[i]]   <= (disp_type_i[2*i +: 2] == 2'd3) ? 2'd0 : disp_type_i[2*i +: 2];
                        r_pd[w_disp_idx[i]]     <= disp_pd_i[PREG_W*i +: PREG_W];
                        r_old_pd[w_disp_idx[i]] <= disp_old_pd_i[PREG_W*i +: PREG_W];
                        r_pc[w_disp_idx[i]]     <= disp_pc_i[PC_W*i +: PC_W];
                        r_result[w_disp_idx[i]] <= '0;
                    end
                end
            end
        end
    end

    // Retirement output registers; slots that do not retire carry zeros
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rt_valid  <= '0;
            r_rt_type   <= '0;
            r_rt_pd     <= '0;
            r_rt_old_pd <= '0;
            r_rt_result <= '0;
            r_rt_pc     <= '0;
        end else if (w_flush) begin
            r_rt_valid  <= '0;
            r_rt_type   <= '0;
            r_rt_pd     <= '0;
            r_rt_old_pd <= '0;
            r_rt_result <= '0;
            r_rt_pc     <= '0;
        end else begin
            for (int k = 0; k < RET_W; k++) begin
                if (w_ret_ok[k]) begin
                    r_rt_valid[k]                   <= 1'b1;
                    r_rt_type[2*k +: 2]             <= r_type[w_ret_idx[k]];
                    r_rt_pd[PREG_W*k +: PREG_W]     <= r_pd[w_ret_idx[k]];
                    r_rt_old_pd[PREG_W*k +: PREG_W] <= r_old_pd[w_ret_idx[k]];
                    r_rt_result[DATA_W*k +: DATA_W] <= r_result[w_ret_idx[k]];
                    r_rt_pc[PC_W*k +: PC_W]         <= r_pc[w_ret_idx[k]];
                end else begin
                    r_rt_valid[k]                   <= 1'b0;
                    r_rt_type[2*k +: 2]             <= 2'd0;
                    r_rt_pd[PREG_W*k +: PREG_W]     <= '0;
                    r_rt_old_pd[PREG_W*k +: PREG_W] <= '0;
                    r_rt_result[DATA_W*k +: DATA_W] <= '0;
                    r_rt_pc[PC_W*k +: PC_W]         <= '0;
                end
            end
        end
    end

    assign disp_ready_o = w_ready;
    assign rt_valid_o   = r_rt_valid;
    assign rt_type_o    = r_rt_type;
    assign rt_pd_o      = r_rt_pd;
    assign rt_old_pd_o  = r_rt_old_pd;
    assign rt_result_o  = r_rt_result;
    assign rt_pc_o      = r_rt_pc;
    assign count_o      = r_count;
    assign empty_o      = (r_count == CNT_W'(0));
    assign full_o       = (r_count == CNT_W'(DEPTH));

endmodule

// File: tb/tb_rob_retire_unit.sv
// Testbench for rob_retire_unit: directed scenarios plus randomized traffic,
// checked against a queue-based reference model of the re-order buffer.
module tb_rob_retire_unit;

    localparam int DEPTH   = 16;
    localparam int DISP_W  = 2;
    localparam int NUM_CMP = 3;
    localparam int RET_W   = 2;
    localparam int PREG_W  = 6;
    localparam int DATA_W  = 32;
    localparam int PC_W    = 7;
    localparam int TAG_W   = 4;

    logic                      clk_i;
    logic                      rst_ni;
    logic                      flush_s;
    logic [DISP_W-1:0]         disp_valid_i;
    logic                      disp_ready_o;
    logic [2*DISP_W-1:0]       disp_type_i;
    logic [PREG_W*DISP_W-1:0]  disp_pd_i;
    logic [PREG_W*DISP_W-1:0]  disp_old_pd_i;
    logic [PC_W*DISP_W-1:0]    disp_pc_i;
    logic [TAG_W*DISP_W-1:0]   disp_tag_o;
    logic [NUM_CMP-1:0]        cmp_valid_i;
    logic [TAG_W*NUM_CMP-1:0]  cmp_tag_i;
    logic [DATA_W*NUM_CMP-1:0] cmp_result_i;
    logic [RET_W-1:0]          rt_valid_o;
    logic [2*RET_W-1:0]        rt_type_o;
    logic [PREG_W*RET_W-1:0]   rt_pd_o;
    logic [PREG_W*RET_W-1:0]   rt_old_pd_o;
    logic [DATA_W*RET_W-1:0]   rt_result_o;
    logic [PC_W*RET_W-1:0]     rt_pc_o;
    logic [TAG_W:0]            count_o;
    logic                      empty_o;
    logic                      full_o;

    int checks;
    int failures;

    rob_retire_unit dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
`ifdef ROB_FLUSH_EN
        .flush_i       (flush_s),
`endif
        .disp_valid_i  (disp_valid_i),
        .disp_ready_o  (disp_ready_o),
        .disp_type_i   (disp_type_i),
        .disp_pd_i     (disp_pd_i),
        .disp_old_pd_i (disp_old_pd_i),
        .disp_pc_i     (disp_pc_i),
        .disp_tag_o    (disp_tag_o),
        .cmp_valid_i   (cmp_valid_i),
        .cmp_tag_i     (cmp_tag_i),
        .cmp_result_i  (cmp_result_i),
        .rt_valid_o    (rt_valid_o),
        .rt_type_o     (rt_type_o),
        .rt_pd_o       (rt_pd_o),
        .rt_old_pd_o   (rt_old_pd_o),
        .rt_result_o   (rt_result_o),
        .rt_pc_o       (rt_pc_o),
        .count_o       (count_o),
        .empty_o       (empty_o),
        .full_o        (full_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // ---------------- reference model ----------------
    typedef struct {
        int                tag;
        logic [1:0]        typ;
        logic [PREG_W-1:0] pd;
        logic [PREG_W-1:0] opd;
        logic [PC_W-1:0]   pc;
        bit                comp;
        logic [DATA_W-1:0] res;
    } ent_t;

    ent_t m_q[$];
    int   m_tail;
    logic [RET_W-1:0]        e_rt_valid;
    logic [2*RET_W-1:0]      e_rt_type;
    logic [PREG_W*RET_W-1:0] e_rt_pd;
    logic [PREG_W*RET_W-1:0] e_rt_old_pd;
    logic [DATA_W*RET_W-1:0] e_rt_result;
    logic [PC_W*RET_W-1:0]   e_rt_pc;

    function automatic logic [TAG_W:0] exp_count();
        return (TAG_W+1)'(m_q.size());
    endfunction

    function automatic logic exp_ready();
        return (DEPTH - m_q.size()) >= DISP_W;
    endfunction

    function automatic logic [TAG_W*DISP_W-1:0] exp_tags();
        logic [TAG_W*DISP_W-1:0] t;
        for (int i = 0; i < DISP_W; i++) t[TAG_W*i +: TAG_W] = TAG_W'((m_tail + i) % DEPTH);
        return t;
    endfunction

    task automatic clear_inputs();
        flush_s       = 1'b0;
        disp_valid_i  = '0;
        disp_type_i   = '0;
        disp_pd_i     = '0;
        disp_old_pd_i = '0;
        disp_pc_i     = '0;
        cmp_valid_i   = '0;
        cmp_tag_i     = '0;
        cmp_result_i  = '0;
    endtask

    task automatic set_lane(input int i, input logic [1:0] t, input logic [PREG_W-1:0] pd,
                            input logic [PREG_W-1:0] opd, input logic [PC_W-1:0] pc);
        disp_valid_i[i]                  = 1'b1;
        disp_type_i[2*i +: 2]            = t;
        disp_pd_i[PREG_W*i +: PREG_W]    = pd;
        disp_old_pd_i[PREG_W*i +: PREG_W] = opd;
        disp_pc_i[PC_W*i +: PC_W]        = pc;
    endtask

    task automatic set_cmp(input int p, input int tag, input logic [DATA_W-1:0] res);
        cmp_valid_i[p]                 = 1'b1;
        cmp_tag_i[TAG_W*p +: TAG_W]    = TAG_W'(tag);
        cmp_result_i[DATA_W*p +: DATA_W] = res;
    endtask

    // Advance the model by one edge using the current inputs, then clock the DUT.
    task automatic step();
        int   nret;
        int   pre;
        ent_t e;
        e_rt_valid = '0; e_rt_type = '0; e_rt_pd = '0;
        e_rt_old_pd = '0; e_rt_result = '0; e_rt_pc = '0;
        pre = m_q.size();
        if (flush_s) begin
            m_q.delete();
        end else begin
            nret = 0;
            while (nret < RET_W && nret < m_q.size()) begin
                if (!m_q[nret].comp) break;
                e_rt_valid[nret]                    = 1'b1;
                e_rt_type[2*nret +: 2]              = m_q[nret].typ;
                e_rt_pd[PREG_W*nret +: PREG_W]      = m_q[nret].pd;
                e_rt_old_pd[PREG_W*nret +: PREG_W]  = m_q[nret].opd;
                e_rt_result[DATA_W*nret +: DATA_W]  = m_q[nret].res;
                e_rt_pc[PC_W*nret +: PC_W]          = m_q[nret].pc;
                nret++;
            end
            for (int p = 0; p < NUM_CMP; p++) begin
                if (cmp_valid_i[p]) begin
                    for (int j = 0; j < m_q.size(); j++) begin
                        if (m_q[j].tag == int'(cmp_tag_i[TAG_W*p +: TAG_W])) begin
                            e = m_q[j];
                            e.comp = 1'b1;
                            e.res  = cmp_result_i[DATA_W*p +: DATA_W];
                            m_q[j] = e;
                        end
                    end
                end
            end
            repeat (nret) void'(m_q.pop_front());
            if ((DEPTH - pre) >= DISP_W) begin
                for (int i = 0; i < DISP_W; i++) begin
                    if (disp_valid_i[i]) begin
                        e.tag  = m_tail;
                        e.typ  = (disp_type_i[2*i +: 2] == 2'd3) ? 2'd0 : disp_type_i[2*i +: 2];
                        e.pd   = disp_pd_i[PREG_W*i +: PREG_W];
                        e.opd  = disp_old_pd_i[PREG_W*i +: PREG_W];
                        e.pc   = disp_pc_i[PC_W*i +: PC_W];
                        e.comp = 1'b0;
                        e.res  = '0;
                        m_q.push_back(e);
                        m_tail = (m_tail + 1) % DEPTH;
                    end
                end
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear_inputs();
        rst_ni = 1'b0;
        m_q.delete();
        m_tail = 0;
        e_rt_valid = '0; e_rt_type = '0; e_rt_pd = '0;
        e_rt_old_pd = '0; e_rt_result = '0; e_rt_pc = '0;
        #1;
        checks++;
        if (count_o !== 5'd0 || empty_o !== 1'b1 || rt_valid_o !== 2'b00) begin
            failures++;
            $display("FAIL reset_async count=%0d empty=%b rt_valid=%b required 0/1/00", count_o, empty_o, rt_valid_o);
        end
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        checks++;
        if (count_o !== 5'd0 || empty_o !== 1'b1 || full_o !== 1'b0 || disp_ready_o !== 1'b1 ||
            rt_valid_o !== 2'b00 || disp_tag_o !== 8'h10 || rt_result_o !== 64'd0) begin
            failures++;
            $display("FAIL reset_state count=%0d empty=%b full=%b ready=%b rt_valid=%b tags=%h res=%h required 0/1/0/1/00/10/0",
                     count_o, empty_o, full_o, disp_ready_o, rt_valid_o, disp_tag_o, rt_result_o);
        end
    endtask

    task automatic test_out_of_order();
        clear_inputs();
        checks++;
        if (disp_tag_o !== 8'h10) begin
            failures++;
            $display("FAIL ooo_tags got %h required 10", disp_tag_o);
        end
        set_lane(0, 2'd0, 6'd33, 6'd3, 7'd20);
        set_lane(1, 2'd0, 6'd34, 6'd4, 7'd21);
        step();
        clear_inputs();
        set_cmp(0, 1, 32'd7);
        step();
        clear_inputs();
        set_cmp(0, 0, 32'd5);
        step();
        checks++;
        if (rt_valid_o !== 2'b00 || count_o !== 5'd2) begin
            failures++;
            $display("FAIL ooo_hold rt_valid=%b count=%0d required 00 and 2", rt_valid_o, count_o);
        end
        clear_inputs();
        step();
        checks++;
        if (rt_valid_o !== 2'b11 || rt_result_o !== {32'd7, 32'd5} || rt_pd_o !== {6'd34, 6'd33} ||
            rt_old_pd_o !== {6'd4, 6'd3} || rt_pc_o !== {7'd21, 7'd20} || count_o !== 5'd0) begin
            failures++;
            $display("FAIL ooo_retire v=%b res=%h pd=%h opd=%h pc=%h count=%0d required 11/%h/%h/%h/%h/0",
                     rt_valid_o, rt_result_o, rt_pd_o, rt_old_pd_o, rt_pc_o, count_o,
                     {32'd7, 32'd5}, {6'd34, 6'd33}, {6'd4, 6'd3}, {7'd21, 7'd20});
        end
        step();
        checks++;
        if (rt_valid_o !== 2'b00 || rt_result_o !== 64'd0) begin
            failures++;
            $display("FAIL ooo_one_cycle v=%b res=%h required 00/0", rt_valid_o, rt_result_o);
        end
    endtask

    task automatic test_full();
        clear_inputs();
        for (int n = 0; n < 8; n++) begin
            set_lane(0, 2'd1, 6'(2*n), 6'd1, 7'(2*n));
            set_lane(1, 2'd2, 6'(2*n+1), 6'd2, 7'(2*n+1));
            step();
        end
        checks++;
        if (full_o !== 1'b1 || disp_ready_o !== 1'b0 || count_o !== 5'd16 || empty_o !== 1'b0) begin
            failures++;
            $display("FAIL full_state full=%b ready=%b count=%0d empty=%b required 1/0/16/0",
                     full_o, disp_ready_o, count_o, empty_o);
        end
        step();
        checks++;
        if (count_o !== 5'd16 || disp_tag_o !== 8'h10 || rt_valid_o !== 2'b00) begin
            failures++;
            $display("FAIL full_ignore count=%0d tags=%h rt_valid=%b required 16/10/00", count_o, disp_tag_o, rt_valid_o);
        end
    endtask

    task automatic test_wrap();
        clear_inputs();
        for (int n = 0; n < 7; n++) begin
            set_lane(0, 2'd0, 6'(2*n), 6'd0, 7'd0);
            set_lane(1, 2'd0, 6'(2*n+1), 6'd0, 7'd0);
            step();
        end
        clear_inputs();
        for (int t = 0; t < 14; t += 3) begin
            clear_inputs();
            for (int p = 0; p < NUM_CMP; p++) if (t + p < 14) set_cmp(p, t + p, 32'(100 + t + p));
            step();
        end
        clear_inputs();
        for (int n = 0; n < 8; n++) step();
        checks++;
        if (count_o !== 5'd0 || disp_tag_o !== 8'hFE) begin
            failures++;
            $display("FAIL wrap_drain count=%0d tags=%h required 0/fe", count_o, disp_tag_o);
        end
        set_lane(0, 2'd0, 6'd14, 6'd0, 7'd14);
        set_lane(1, 2'd0, 6'd15, 6'd0, 7'd15);
        step();
        checks++;
        if (disp_tag_o !== 8'h10) begin
            failures++;
            $display("FAIL wrap_tags got %h required 10", disp_tag_o);
        end
        set_lane(0, 2'd0, 6'd0, 6'd0, 7'd0);
        set_lane(1, 2'd0, 6'd1, 6'd0, 7'd1);
        step();
        clear_inputs();
        set_cmp(0, 14, 32'd14); set_cmp(1, 15, 32'd15); set_cmp(2, 0, 32'd0);
        step();
        clear_inputs();
        set_cmp(0, 1, 32'd1);
        step();
        checks++;
        if (rt_valid_o !== 2'b11 || rt_pd_o !== {6'd15, 6'd14} || rt_result_o !== e_rt_result) begin
            failures++;
            $display("FAIL wrap_first v=%b pd=%h res=%h required 11/%h/%h", rt_valid_o, rt_pd_o, rt_result_o,
                     {6'd15, 6'd14}, e_rt_result);
        end
        clear_inputs();
        step();
        checks++;
        if (rt_valid_o !== 2'b11 || rt_pd_o !== {6'd1, 6'd0} || rt_result_o !== {32'd1, 32'd0} || count_o !== 5'd0) begin
            failures++;
            $display("FAIL wrap_second v=%b pd=%h res=%h count=%0d required 11/%h/%h/0", rt_valid_o, rt_pd_o,
                     rt_result_o, count_o, {6'd1, 6'd0}, {32'd1, 32'd0});
        end
    endtask

    task automatic test_same_tag();
        clear_inputs();
        for (int n = 0; n < 2; n++) begin
            set_lane(0, 2'd2, 6'(10+2*n), 6'd0, 7'd0);
            set_lane(1, 2'd1, 6'(11+2*n), 6'd0, 7'd0);
            step();
        end
        clear_inputs();
        set_cmp(0, 0, 32'd1); set_cmp(1, 1, 32'd2); set_cmp(2, 2, 32'd3);
        step();
        clear_inputs();
        set_cmp(0, 3, 32'd11); set_cmp(2, 3, 32'd22);
        step();
        clear_inputs();
        step();
        checks++;
        if (rt_valid_o !== 2'b11 || rt_result_o !== {32'd22, 32'd3} || rt_type_o !== {2'd1, 2'd2}) begin
            failures++;
            $display("FAIL same_tag v=%b res=%h type=%b required 11/%h/0110", rt_valid_o, rt_result_o, rt_type_o,
                     {32'd22, 32'd3});
        end
    endtask

`ifdef ROB_FLUSH_EN
    task automatic test_flush();
        clear_inputs();
        for (int n = 0; n < 3; n++) begin
            set_lane(0, 2'd0, 6'(n), 6'd0, 7'd0);
            set_lane(1, 2'd0, 6'(n+8), 6'd0, 7'd0);
            step();
        end
        clear_inputs();
        set_cmp(0, 0, 32'd9); set_cmp(1, 1, 32'd8);
        step();
        clear_inputs();
        flush_s = 1'b1;
        set_cmp(0, 2, 32'd7);
        step();
        checks++;
        if (count_o !== 5'd0 || rt_valid_o !== 2'b00 || empty_o !== 1'b1) begin
            failures++;
            $display("FAIL flush_clear count=%0d rt_valid=%b empty=%b required 0/00/1", count_o, rt_valid_o, empty_o);
        end
        clear_inputs();
        step();
        checks++;
        if (rt_valid_o !== 2'b00 || count_o !== 5'd0 || disp_tag_o !== exp_tags()) begin
            failures++;
            $display("FAIL flush_after rt_valid=%b count=%0d tags=%h required 00/0/%h", rt_valid_o, count_o,
                     disp_tag_o, exp_tags());
        end
    endtask
`endif

    task automatic test_random(input int cycles);
        int pick;
        for (int c = 0; c < cycles; c++) begin
            clear_inputs();
            pick = $urandom_range(0, 2);
            for (int i = 0; i < pick && i < DISP_W; i++)
                set_lane(i, 2'($urandom_range(0, 3)), 6'($urandom), 6'($urandom), 7'($urandom));
            for (int p = 0; p < NUM_CMP; p++) begin
                if ($urandom_range(0, 1) == 1) begin
                    if (m_q.size() > 0 && $urandom_range(0, 4) != 0)
                        set_cmp(p, m_q[$urandom_range(0, m_q.size() - 1)].tag, $urandom);
                    else
                        set_cmp(p, $urandom_range(0, DEPTH - 1), $urandom);
                end
            end
            step();
            checks++;
            if (rt_valid_o !== e_rt_valid || rt_result_o !== e_rt_result || rt_pd_o !== e_rt_pd ||
                rt_old_pd_o !== e_rt_old_pd || rt_pc_o !== e_rt_pc || rt_type_o !== e_rt_type) begin
                failures++;
                $display("FAIL rand_retire cyc=%0d got v=%b t=%b pd=%h opd=%h pc=%h res=%h required v=%b t=%b pd=%h opd=%h pc=%h res=%h",
                         c, rt_valid_o, rt_type_o, rt_pd_o, rt_old_pd_o, rt_pc_o, rt_result_o,
                         e_rt_valid, e_rt_type, e_rt_pd, e_rt_old_pd, e_rt_pc, e_rt_result);
            end
            checks++;
            if (count_o !== exp_count() || disp_ready_o !== exp_ready() || disp_tag_o !== exp_tags() ||
                empty_o !== (m_q.size() == 0) || full_o !== (m_q.size() == DEPTH)) begin
                failures++;
                $display("FAIL rand_status cyc=%0d got count=%0d ready=%b tags=%h empty=%b full=%b required %0d/%b/%h/%b/%b",
                         c, count_o, disp_ready_o, disp_tag_o, empty_o, full_o, exp_count(), exp_ready(),
                         exp_tags(), m_q.size() == 0, m_q.size() == DEPTH);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        m_tail   = 0;
        rst_ni   = 1'b0;
        clear_inputs();
        test_reset();
        test_out_of_order();
        test_reset();
        test_full();
        test_reset();
        test_wrap();
        test_reset();
        test_same_tag();
`ifdef ROB_FLUSH_EN
        test_reset();
        test_flush();
`endif
        test_reset();
        test_random(400);
        test_reset();
        test_random(200);
        test_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
